// File: rtl/bootrom_ldr_pkg.sv
// Shared definitions for the bootrom_ldr boot memory and its byte-stream loader.
// Optional build macro used by this design: BTRM_RDFWD_EN (port B write-first forwarding).
package bootrom_ldr_pkg;

   localparam int BYTE_W = 8;

   // Widest supported word is 64 bits, so eight lanes cover every configuration.
   localparam logic [7:0] LANE_ALL = 8'hFF;

   typedef enum logic [1:0] {
      LD_IDLE   = 2'd0,
      LD_FILL   = 2'd1,
      LD_COMMIT = 2'd2
   } ld_state_t;

   // Number of bits needed to represent value (clogb2(65535) = 16).
   function automatic int clogb2(input int value);
      int r;
      r = 0;
      for (int v = value; v > 0; v = v >> 1) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/bootrom_ldr_ram.sv
// Dual read-port RAM with a single byte-enable write port, kept free of loader logic.
// BTRM_RDFWD_EN selects write-first read data on port B and loader-commit forwarding on port A.
module bootrom_ldr_ram
   import bootrom_ldr_pkg::*;
#(
   parameter  int DW    = 32,
   parameter  int DEPTH = 65536,
   localparam int AW    = clogb2(DEPTH - 1),
   localparam int NB    = DW / BYTE_W
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_ena,
   input  logic [AW-1:0] i_addra,
   output logic [DW-1:0] o_douta,
   input  logic          i_enb,
   input  logic [AW-1:0] i_addrb,
   output logic [DW-1:0] o_doutb,
   input  logic [NB-1:0] i_wem,
   input  logic [AW-1:0] i_addrw,
   input  logic [DW-1:0] i_dinw,
`ifdef BTRM_RDFWD_EN
   input  logic          i_lwr,
`endif
   input  logic          i_bwr
);

   logic [DW-1:0] r_mem [DEPTH];

`ifdef BTRM_RDFWD_EN
   logic [DW-1:0] w_merged;

   always_comb begin
      w_merged = r_mem[i_addrw];
      for (int i = 0; i < NB; i++) begin
         if (i_wem[i]) w_merged[i*BYTE_W +: BYTE_W] = i_dinw[i*BYTE_W +: BYTE_W];
      end
   end
`endif

   // NOTE: the array has no reset so it maps onto block RAM; only the output registers reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NB; i++) begin
         if (i_wem[i]) r_mem[i_addrw][i*BYTE_W +: BYTE_W] <= i_dinw[i*BYTE_W +: BYTE_W];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_douta <= '0;
         o_doutb <= '0;
      end else begin
`ifdef BTRM_RDFWD_EN
         if (i_ena) begin
            if (i_lwr && (i_addra == i_addrw)) o_douta <= w_merged;
            else                               o_douta <= r_mem[i_addra];
         end
         if (i_bwr)      o_doutb <= w_merged;
         else if (i_enb) o_doutb <= r_mem[i_addrb];
`else
         if (i_ena)            o_douta <= r_mem[i_addra];
         if (i_enb && !i_bwr)  o_doutb <= r_mem[i_addrb];
`endif
      end
   end

endmodule

// File: rtl/bootrom_ldr.sv
// Boot memory with bus/fetch read ports and a byte-stream loader that packs bytes into words.
// Optional build macro: BTRM_RDFWD_EN (write-first port B, loader-commit forwarding to port A).
module bootrom_ldr
   import bootrom_ldr_pkg::*;
#(
   parameter  int DW    = 32,
   parameter  int DEPTH = 65536,
   localparam int AW    = clogb2(DEPTH - 1),
   localparam int NB    = DW / BYTE_W
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_ena,
   input  logic [AW-1:0] i_addra,
   output logic [DW-1:0] o_douta,
   input  logic          i_enb,
   input  logic [NB-1:0] i_web,
   input  logic [AW-1:0] i_addrb,
   input  logic [DW-1:0] i_dinb,
   output logic [DW-1:0] o_doutb,
   input  logic          i_ld_start,
   input  logic [AW-1:0] i_ld_base,
   input  logic          i_ld_valid,
   input  logic [7:0]    i_ld_byte,
   output logic          o_ld_ready,
   output logic          o_ld_busy,
   input  logic          i_ld_stop,
   output logic [AW:0]   o_ld_cnt
);

   localparam int            IW       = clogb2(NB);
   localparam logic [AW:0]   CNT_MAX  = (AW + 1)'(DEPTH);
   localparam logic [IW-1:0] IDX_LAST = IW'(NB - 1);

   ld_state_t     r_state, w_state_nxt;
   logic [AW-1:0] r_ptr,   w_ptr_nxt;
   logic [IW-1:0] r_idx,   w_idx_nxt;
   logic [DW-1:0] r_word,  w_word_nxt;
   logic [NB-1:0] r_mask,  w_mask_nxt;
   logic [AW:0]   r_cnt,   w_cnt_nxt;
   logic          r_stop,  w_stop_nxt;
   logic          w_bus_wr, w_accept, w_commit;
   logic [NB-1:0] w_wem;
   logic [AW-1:0] w_addrw;
   logic [DW-1:0] w_dinw;

   assign w_bus_wr = i_enb && (i_web != '0);

   // NOTE: every variable gets a default first so no path through the case infers a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_idx_nxt   = r_idx;
      w_word_nxt  = r_word;
      w_mask_nxt  = r_mask;
      w_cnt_nxt   = r_cnt;
      w_stop_nxt  = r_stop;
      o_ld_ready  = 1'b0;
      w_accept    = 1'b0;
      w_commit    = 1'b0;

      case (r_state)
         LD_IDLE: ;
         LD_FILL: begin
            o_ld_ready = 1'b1;
            w_accept   = i_ld_valid;
            if (w_accept) begin
               for (int i = 0; i < NB; i++) begin
                  if (r_idx == IW'(i)) begin
                     w_word_nxt[i*BYTE_W +: BYTE_W] = i_ld_byte;
                     w_mask_nxt[i]                  = 1'b1;
                  end
               end
               w_idx_nxt = r_idx + 1'b1;
            end
            if (w_accept && (r_idx == IDX_LAST)) begin
               w_state_nxt = LD_COMMIT;
               w_mask_nxt  = LANE_ALL[NB-1:0];
               w_stop_nxt  = i_ld_stop;
            end else if (i_ld_stop) begin
               // Flush whatever lanes are filled; an empty word just ends the load.
               if (w_accept || (r_idx != '0)) begin
                  w_state_nxt = LD_COMMIT;
                  w_stop_nxt  = 1'b1;
               end else begin
                  w_state_nxt = LD_IDLE;
               end
            end
         end
         LD_COMMIT: begin
            w_stop_nxt = r_stop || i_ld_stop;
            if (!w_bus_wr) begin
               w_commit    = 1'b1;
               w_ptr_nxt   = r_ptr + 1'b1;
               w_idx_nxt   = '0;
               w_mask_nxt  = '0;
               w_stop_nxt  = 1'b0;
               w_state_nxt = (r_stop || i_ld_stop) ? LD_IDLE : LD_FILL;
               if (r_cnt != CNT_MAX) w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         default: w_state_nxt = LD_IDLE;
      endcase

      if (i_ld_start) begin
         w_state_nxt = LD_FILL;
         w_ptr_nxt   = i_ld_base;
         w_idx_nxt   = '0;
         w_mask_nxt  = '0;
         w_cnt_nxt   = '0;
         w_stop_nxt  = 1'b0;
         w_commit    = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= LD_IDLE;
         r_ptr   <= '0;
         r_idx   <= '0;
         r_word  <= '0;
         r_mask  <= '0;
         r_cnt   <= '0;
         r_stop  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
         r_idx   <= w_idx_nxt;
         r_word  <= w_word_nxt;
         r_mask  <= w_mask_nxt;
         r_cnt   <= w_cnt_nxt;
         r_stop  <= w_stop_nxt;
      end
   end

   // Bus writes own the write port; the loader only writes when it is free.
   assign w_wem   = w_bus_wr ? i_web   : (w_commit ? r_mask : '0);
   assign w_addrw = w_bus_wr ? i_addrb : r_ptr;
   assign w_dinw  = w_bus_wr ? i_dinb  : r_word;

   assign o_ld_busy = (r_state != LD_IDLE);
   assign o_ld_cnt  = r_cnt;

   bootrom_ldr_ram #(
      .DW    (DW),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .i_ena   (i_ena),
      .i_addra (i_addra),
      .o_douta (o_douta),
      .i_enb   (i_enb),
      .i_addrb (i_addrb),
      .o_doutb (o_doutb),
      .i_wem   (w_wem),
      .i_addrw (w_addrw),
      .i_dinw  (w_dinw),
`ifdef BTRM_RDFWD_EN
      .i_lwr   (w_commit),
`endif
      .i_bwr   (w_bus_wr)
   );

endmodule

// File: tb/tb_bootrom_ldr.sv
// Scoreboard bench for bootrom_ldr: read expectations are queued at issue and checked by a monitor.
// Built without BTRM_RDFWD_EN, so port B read-first/hold behaviour is expected.
module tb_bootrom_ldr;

   localparam int DW    = 32;
   localparam int DEPTH = 65536;
   localparam int AW    = 16;
   localparam int NB    = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          ena = 1'b0;
   logic [AW-1:0] addra = '0;
   logic [DW-1:0] douta;
   logic          enb = 1'b0;
   logic [NB-1:0] web = '0;
   logic [AW-1:0] addrb = '0;
   logic [DW-1:0] dinb = '0;
   logic [DW-1:0] doutb;
   logic          ld_start = 1'b0;
   logic [AW-1:0] ld_base = '0;
   logic          ld_valid = 1'b0;
   logic [7:0]    ld_byte = '0;
   logic          ld_ready;
   logic          ld_busy;
   logic          ld_stop = 1'b0;
   logic [AW:0]   ld_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   logic [DW-1:0] qa[$];
   logic [DW-1:0] qb[$];
   logic          pa = 1'b0;
   logic          pb = 1'b0;

   always #5 clk = ~clk;

   bootrom_ldr #(.DW(DW), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .i_ena      (ena),
      .i_addra    (addra),
      .o_douta    (douta),
      .i_enb      (enb),
      .i_web      (web),
      .i_addrb    (addrb),
      .i_dinb     (dinb),
      .o_doutb    (doutb),
      .i_ld_start (ld_start),
      .i_ld_base  (ld_base),
      .i_ld_valid (ld_valid),
      .i_ld_byte  (ld_byte),
      .o_ld_ready (ld_ready),
      .o_ld_busy  (ld_busy),
      .i_ld_stop  (ld_stop),
      .o_ld_cnt   (ld_cnt)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // A read issued before a rising edge presents data at the following falling edge.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         pa <= 1'b0;
         pb <= 1'b0;
      end else begin
         pa <= ena;
         pb <= enb && (web == '0);
      end
   end

   always @(negedge clk) begin
      if (pa) begin
         if (qa.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL douta_unexpected: got 0x%0h, expected no read", douta);
         end else check("douta", douta, qa.pop_front());
      end
      if (pb) begin
         if (qb.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL doutb_unexpected: got 0x%0h, expected no read", doutb);
         end else check("doutb", doutb, qb.pop_front());
      end
   end

   task automatic bus_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] m);
      enb = 1'b1; web = m; addrb = a; dinb = d;
      @(negedge clk);
      enb = 1'b0; web = '0;
   endtask

   task automatic read_a(input logic [AW-1:0] a, input logic [DW-1:0] e);
      qa.push_back(e);
      ena = 1'b1; addra = a;
      @(negedge clk);
      ena = 1'b0;
   endtask

   task automatic read_b(input logic [AW-1:0] a, input logic [DW-1:0] e);
      qb.push_back(e);
      enb = 1'b1; web = '0; addrb = a;
      @(negedge clk);
      enb = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int wait_n;
      wait_n = 0;
      ld_valid = 1'b1; ld_byte = b;
      while (!ld_ready && wait_n < 20) begin
         @(negedge clk);
         wait_n++;
      end
      if (!ld_ready) begin
         n_checks++; n_fail++;
         $display("FAIL ld_ready_timeout: got ld_ready=0, expected 1 within 20 cycles");
      end else begin
         @(negedge clk);
      end
      ld_valid = 1'b0;
   endtask

   task automatic start_load(input logic [AW-1:0] base);
      ld_base = base; ld_start = 1'b1;
      @(negedge clk);
      ld_start = 1'b0;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("rst_douta", douta, 0);
      check("rst_doutb", doutb, 0);
      check("rst_ready", ld_ready, 0);
      check("rst_busy", ld_busy, 0);
      check("rst_cnt", ld_cnt, 0);
      rst = 1'b0;
      @(negedge clk);

      // Full-word bus write then fetch read, plus known background words.
      bus_write(16'h0010, 32'hDEADBEEF, 4'hF);
      read_a(16'h0010, 32'hDEADBEEF);
      bus_write(16'h0022, 32'hCAFEBABE, 4'hF);
      bus_write(16'h0041, 32'h0BADF00D, 4'hF);
      bus_write(16'h0061, 32'h12345678, 4'hF);

      // Single-lane write, both read ports, doutb holds across a write.
      bus_write(16'h0010, 32'h0000AA00, 4'b0010);
      read_a(16'h0010, 32'hDEADAAEF);
      read_b(16'h0010, 32'hDEADAAEF);
      bus_write(16'h0011, 32'h11111111, 4'hF);
      check("doutb_hold", doutb, 32'hDEADAAEF);

      // Same-address A read and B write: A returns the old word.
      qa.push_back(32'hDEADAAEF);
      ena = 1'b1; addra = 16'h0010;
      enb = 1'b1; web = 4'hF; addrb = 16'h0010; dinb = 32'h01020304;
      @(negedge clk);
      ena = 1'b0; enb = 1'b0; web = '0;
      read_a(16'h0010, 32'h01020304);

      // Loader: two full words at 0x20.
      start_load(16'h0020);
      check("busy_start", ld_busy, 1);
      check("ready_fill", ld_ready, 1);
      for (int i = 1; i <= 8; i++) send_byte(8'(i));
      @(negedge clk);
      check("cnt_two", ld_cnt, 2);
      read_a(16'h0020, 32'h04030201);
      read_a(16'h0021, 32'h08070605);

      // Partial word flush on stop: upper lanes of 0x22 untouched.
      send_byte(8'h11);
      send_byte(8'h22);
      ld_stop = 1'b1;
      @(negedge clk);
      ld_stop = 1'b0;
      check("ready_flush", ld_ready, 0);
      @(negedge clk);
      check("busy_stop", ld_busy, 0);
      check("cnt_stop", ld_cnt, 3);
      check("ready_idle", ld_ready, 0);
      read_a(16'h0022, 32'hCAFE2211);

      // Commit collides with a bus write elsewhere: bus wins, loader retries.
      start_load(16'h0040);
      check("cnt_restart", ld_cnt, 0);
      send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3); send_byte(8'hA4);
      check("ready_commit", ld_ready, 0);
      enb = 1'b1; web = 4'hF; addrb = 16'h0050; dinb = 32'h55667788;
      @(negedge clk);
      enb = 1'b0; web = '0;
      check("ready_retry", ld_ready, 0);
      check("cnt_retry", ld_cnt, 0);
      @(negedge clk);
      check("ready_after_retry", ld_ready, 1);
      check("cnt_after_retry", ld_cnt, 1);
      read_a(16'h0040, 32'hA4A3A2A1);
      read_b(16'h0050, 32'h55667788);

      // Restart while busy discards the partial byte, then reset mid-fill.
      send_byte(8'h99);
      start_load(16'h0060);
      check("cnt_restart2", ld_cnt, 0);
      send_byte(8'hC1); send_byte(8'hC2); send_byte(8'hC3); send_byte(8'hC4);
      @(negedge clk);
      check("cnt_one", ld_cnt, 1);
      send_byte(8'hD1); send_byte(8'hD2); send_byte(8'hD3);
      rst = 1'b1;
      #1;
      check("rst2_busy", ld_busy, 0);
      check("rst2_ready", ld_ready, 0);
      check("rst2_cnt", ld_cnt, 0);
      check("rst2_douta", douta, 0);
      check("rst2_doutb", doutb, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      read_a(16'h0060, 32'hC4C3C2C1);
      read_a(16'h0061, 32'h12345678);
      read_a(16'h0041, 32'h0BADF00D);
      read_a(16'h0020, 32'h04030201);
      @(negedge clk);
      check("qa_drained", qa.size(), 0);
      check("qb_drained", qb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
